// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit.
//   WIDTH      operand and result width (only 32 is supported)
//   OP_*       operation encodings carried on the op port
//   state_t    controller states
package mdu_pkg;

    localparam int WIDTH = 32;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    function automatic logic op_is_div(input logic [1:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/mdu_negate.sv
// Conditional two's-complement.
//   value   input operand
//   neg     when high, result = -value; otherwise result = value
//   result  output
module mdu_negate #(
    parameter int W = 64
) (
    input  logic [W-1:0] value,
    input  logic         neg,
    output logic [W-1:0] result
);

    assign result = neg ? ((~value) + {{(W-1){1'b0}}, 1'b1}) : value;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative HI/LO multiply/divide unit, fixed 33-cycle latency.
//   clock, reset_n      clock and asynchronous active-low reset
//   start, op           launch MULT/MULTU/DIV/DIVU (sampled in IDLE only)
//   src_a, src_b        multiplicand/dividend, multiplier/divisor
//   mthi, mtlo, wdata   direct HI/LO writes (IDLE only, start wins)
//   busy                high whenever an operation is in flight
//   done                one-cycle pulse after HI/LO take a new result
//   hi, lo              architectural HI/LO registers
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting; accepts start or mthi/mtlo writes
// RUN   | one radix-2 iteration per cycle, 32 iterations
// FIX   | sign correction, result written to hi/lo, done next cycle
module mul_div_unit #(
    parameter int WIDTH = mdu_pkg::WIDTH
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    import mdu_pkg::*;

    state_t           state;
    logic [5:0]       iter;
    logic             is_div_q;
    logic             sign_a_q;
    logic             sign_b_q;
    logic             div_zero_q;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;

    logic             signed_op;
    logic             sign_a;
    logic             sign_b;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    assign signed_op = op_is_signed(op);
    assign sign_a    = signed_op & src_a[WIDTH-1];
    assign sign_b    = signed_op & src_b[WIDTH-1];

    mdu_negate #(.W(WIDTH)) u_mag_a (.value(src_a), .neg(sign_a), .result(mag_a));
    mdu_negate #(.W(WIDTH)) u_mag_b (.value(src_b), .neg(sign_b), .result(mag_b));

    // One iteration. Multiply: acc_lo holds the multiplier and shifts right while
    // the partial product enters from the top. Divide: acc_hi is the partial
    // remainder, acc_lo shifts the dividend out and the quotient bits in.
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH-1:0] div_sub;
    logic             div_ge;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;

    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, mcand_q});
        // Low bits of the difference are exact; with a zero divisor the remainder
        // simply accumulates the dividend, which is what hi must show.
        div_sub   = div_shift[WIDTH-1:0] - mcand_q;
        step_hi   = mul_sum[WIDTH:1];
        step_lo   = {mul_sum[0], acc_lo[WIDTH-1:1]};
        if (is_div_q) begin
            step_hi = div_ge ? div_sub : div_shift[WIDTH-1:0];
            step_lo = {acc_lo[WIDTH-2:0], div_ge};
        end
    end

    // Sign fix-up: full 64-bit product for multiply, quotient in the low half for
    // divide. A zero divisor keeps the all-ones quotient unnegated.
    logic [2*WIDTH-1:0] fix_in;
    logic [2*WIDTH-1:0] fix_out;
    logic               fix_neg;
    logic [WIDTH-1:0]   rem_out;

    assign fix_in  = is_div_q ? {{WIDTH{1'b0}}, acc_lo} : {acc_hi, acc_lo};
    assign fix_neg = (sign_a_q ^ sign_b_q) & ~(is_div_q & div_zero_q);

    mdu_negate #(.W(2*WIDTH)) u_fix_main (.value(fix_in), .neg(fix_neg), .result(fix_out));
    mdu_negate #(.W(WIDTH))   u_fix_rem  (.value(acc_hi), .neg(sign_a_q), .result(rem_out));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            iter       <= '0;
            is_div_q   <= 1'b0;
            sign_a_q   <= 1'b0;
            sign_b_q   <= 1'b0;
            div_zero_q <= 1'b0;
            mcand_q    <= '0;
            acc_hi     <= '0;
            acc_lo     <= '0;
            hi         <= '0;
            lo         <= '0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        is_div_q   <= op_is_div(op);
                        sign_a_q   <= sign_a;
                        sign_b_q   <= sign_b;
                        div_zero_q <= (src_b == '0);
                        iter       <= '0;
                        acc_hi     <= '0;
                        if (op_is_div(op)) begin
                            acc_lo  <= mag_a;
                            mcand_q <= mag_b;
                        end else begin
                            acc_lo  <= mag_b;
                            mcand_q <= mag_a;
                        end
                        state <= RUN;
                    end else begin
                        if (mthi) hi <= wdata;
                        if (mtlo) lo <= wdata;
                    end
                end
                RUN: begin
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                    iter   <= iter + 6'd1;
                    if (iter == 6'd31) state <= FIX;
                end
                FIX: begin
                    if (is_div_q) begin
                        lo <= fix_out[WIDTH-1:0];
                        hi <= rem_out;
                    end else begin
                        {hi, lo} <= fix_out;
                    end
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;

    import mdu_pkg::*;

    logic        clock   = 1'b0;
    logic        reset_n = 1'b0;
    logic        start   = 1'b0;
    logic [1:0]  op      = 2'b00;
    logic [31:0] src_a   = '0;
    logic [31:0] src_b   = '0;
    logic        mthi    = 1'b0;
    logic        mtlo    = 1'b0;
    logic [31:0] wdata   = '0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int passed = 0;
    int total  = 0;

    always #5 clock = ~clock;

    mul_div_unit #(.WIDTH(32)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .src_a   (src_a),
        .src_b   (src_b),
        .mthi    (mthi),
        .mtlo    (mtlo),
        .wdata   (wdata),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    // Called just after a falling edge; returns just after the next falling edge,
    // i.e. one negedge after the accepting rising edge.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        op = o; src_a = a; src_b = b; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    // Counts falling edges until done is seen; 0 means it never came.
    task automatic wait_done(output int cyc);
        cyc = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clock);
            if (done) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clock);
        total++; if (hi !== 32'h0)  $display("FAIL reset_hi: got %h expected 0", hi);   else passed++;
        total++; if (lo !== 32'h0)  $display("FAIL reset_lo: got %h expected 0", lo);   else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
        total++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else passed++;
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_arith(input string name, input logic [1:0] o, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int cyc;
        @(negedge clock);
        issue(o, a, b);
        total++; if (busy !== 1'b1) $display("FAIL %s_busy: got %b expected 1", name, busy); else passed++;
        wait_done(cyc);
        total++; if (cyc !== 33) $display("FAIL %s_latency: got %0d expected 33", name, cyc); else passed++;
        total++; if (hi !== exp_hi) $display("FAIL %s_hi: got %h expected %h", name, hi, exp_hi); else passed++;
        total++; if (lo !== exp_lo) $display("FAIL %s_lo: got %h expected %h", name, lo, exp_lo); else passed++;
        @(negedge clock);
        total++; if (done !== 1'b0) $display("FAIL %s_done_width: got %b expected 0", name, done); else passed++;
    endtask

    task automatic test_mult();
        test_arith("mult_neg3x5", OP_MULT, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1);
        test_arith("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        test_arith("mult_negneg", OP_MULT, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000000, 32'h00000006);
    endtask

    task automatic test_div();
        test_arith("div_neg7by2", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        test_arith("divu_100by7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
    endtask

    task automatic test_div_edge();
        test_arith("divu_by0", OP_DIVU, 32'd100, 32'd0, 32'h00000064, 32'hFFFFFFFF);
        test_arith("div_neg_by0", OP_DIV, 32'hFFFFFF9C, 32'd0, 32'hFFFFFF9C, 32'hFFFFFFFF);
        test_arith("div_overflow", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    endtask

    task automatic test_mthi_mtlo();
        @(negedge clock);
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'h12345678;
        @(negedge clock);
        mthi = 1'b0; mtlo = 1'b0;
        total++; if (hi !== 32'h12345678) $display("FAIL mt_both_hi: got %h expected 12345678", hi); else passed++;
        total++; if (lo !== 32'h12345678) $display("FAIL mt_both_lo: got %h expected 12345678", lo); else passed++;
        mthi = 1'b1; wdata = 32'hA5A5A5A5;
        @(negedge clock);
        mthi = 1'b0;
        total++; if (hi !== 32'hA5A5A5A5) $display("FAIL mthi_only_hi: got %h expected a5a5a5a5", hi); else passed++;
        total++; if (lo !== 32'h12345678) $display("FAIL mthi_only_lo: got %h expected 12345678", lo); else passed++;
    endtask

    task automatic test_start_priority();
        int cyc;
        @(negedge clock);
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'hCAFEBABE;
        issue(OP_MULTU, 32'd3, 32'd4);
        mthi = 1'b0; mtlo = 1'b0;
        total++; if (busy !== 1'b1) $display("FAIL prio_busy: got %b expected 1", busy); else passed++;
        total++; if (hi !== 32'hA5A5A5A5) $display("FAIL prio_hi_held: got %h expected a5a5a5a5", hi); else passed++;
        total++; if (lo !== 32'h12345678) $display("FAIL prio_lo_held: got %h expected 12345678", lo); else passed++;
        wait_done(cyc);
        total++; if (cyc !== 33) $display("FAIL prio_latency: got %0d expected 33", cyc); else passed++;
        total++; if (hi !== 32'd0)  $display("FAIL prio_hi: got %h expected 0", hi); else passed++;
        total++; if (lo !== 32'd12) $display("FAIL prio_lo: got %h expected c", lo); else passed++;
    endtask

    task automatic test_busy_ignore();
        int cyc;
        logic busy_drop;
        cyc = 0;
        busy_drop = 1'b0;
        @(negedge clock);
        issue(OP_MULT, 32'h00001234, 32'h00000010);
        for (int i = 1; i <= 40; i++) begin
            if (i == 10) begin
                op = OP_DIVU; src_a = 32'd99; src_b = 32'd3;
                start = 1'b1; mthi = 1'b1; wdata = 32'hDEADBEEF;
            end else if (i == 11) begin
                start = 1'b0; mthi = 1'b0;
            end
            @(negedge clock);
            if (done) begin
                cyc = i;
                break;
            end
            if (!busy) busy_drop = 1'b1;
        end
        start = 1'b0; mthi = 1'b0;
        total++; if (cyc !== 33) $display("FAIL ignore_latency: got %0d expected 33", cyc); else passed++;
        total++; if (busy_drop !== 1'b0) $display("FAIL ignore_busy_held: got drop=%b expected 0", busy_drop); else passed++;
        total++; if (hi !== 32'h0) $display("FAIL ignore_hi: got %h expected 0", hi); else passed++;
        total++; if (lo !== 32'h00012340) $display("FAIL ignore_lo: got %h expected 00012340", lo); else passed++;
        @(negedge clock);
        total++; if (busy !== 1'b0) $display("FAIL ignore_idle_after: got %b expected 0", busy); else passed++;
    endtask

    task automatic test_reset_mid();
        logic saw_done;
        saw_done = 1'b0;
        @(negedge clock);
        issue(OP_DIV, 32'd1000, 32'd3);
        repeat (19) @(negedge clock);
        reset_n = 1'b0;
        #1;
        total++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b expected 0", busy); else passed++;
        total++; if (hi !== 32'h0) $display("FAIL rstmid_hi: got %h expected 0", hi); else passed++;
        total++; if (lo !== 32'h0) $display("FAIL rstmid_lo: got %h expected 0", lo); else passed++;
        repeat (3) begin
            @(negedge clock);
            if (done) saw_done = 1'b1;
        end
        reset_n = 1'b1;
        repeat (20) begin
            @(negedge clock);
            if (done || busy) saw_done = 1'b1;
        end
        total++; if (saw_done !== 1'b0) $display("FAIL rstmid_no_done: got activity=%b expected 0", saw_done); else passed++;
        test_arith("rstmid_mult6x7", OP_MULT, 32'd6, 32'd7, 32'd0, 32'd42);
    endtask

    task automatic test_back_to_back();
        int cyc;
        @(negedge clock);
        issue(OP_MULTU, 32'h00010000, 32'h00010000);
        wait_done(cyc);
        total++; if (cyc !== 33) $display("FAIL b2b_first_latency: got %0d expected 33", cyc); else passed++;
        total++; if (hi !== 32'h1) $display("FAIL b2b_first_hi: got %h expected 1", hi); else passed++;
        total++; if (lo !== 32'h0) $display("FAIL b2b_first_lo: got %h expected 0", lo); else passed++;
        issue(OP_DIVU, 32'd100, 32'd7);
        total++; if (busy !== 1'b1) $display("FAIL b2b_second_busy: got %b expected 1", busy); else passed++;
        wait_done(cyc);
        total++; if (cyc !== 33) $display("FAIL b2b_second_latency: got %0d expected 33", cyc); else passed++;
        total++; if (hi !== 32'd2)  $display("FAIL b2b_second_hi: got %h expected 2", hi); else passed++;
        total++; if (lo !== 32'd14) $display("FAIL b2b_second_lo: got %h expected e", lo); else passed++;
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div_edge();
        test_mthi_mtlo();
        test_start_priority();
        test_busy_ignore();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
